// File: rtl/exe_stage_pkg.sv
// exe_stage_pkg: shared bus widths, field offsets, div_op bits, alu_op encoding and divider states
package exe_stage_pkg;
  localparam int DS2ES_W = 151;
  localparam int ES2MS_W = 71;
  localparam int DIV_W = 32;
  localparam int DS_GR_WE = 0;
  localparam int DS_DEST = 1;
  localparam int DS_RES_FROM_MEM = 6;
  localparam int DS_MEM_WE = 7;
  localparam int DS_DIV_OP = 8;
  localparam int DS_ST_DATA = 11;
  localparam int DS_SRC2 = 43;
  localparam int DS_SRC1 = 75;
  localparam int DS_ALU_OP = 107;
  localparam int DS_PC = 119;
  localparam int DIV_EN_BIT = 2;
  localparam int DIV_SIGNED_BIT = 1;
  localparam int DIV_REM_BIT = 0;
  localparam int ALU_ADD = 0;
  localparam int ALU_SUB = 1;
  localparam int ALU_SLT = 2;
  localparam int ALU_SLTU = 3;
  localparam int ALU_AND = 4;
  localparam int ALU_NOR = 5;
  localparam int ALU_OR = 6;
  localparam int ALU_XOR = 7;
  localparam int ALU_SLL = 8;
  localparam int ALU_SRL = 9;
  localparam int ALU_SRA = 10;
  localparam int ALU_LUI = 11;
  typedef enum logic [1:0] {DIV_IDLE, DIV_RUN, DIV_DONE} div_state_t;
endpackage

// File: rtl/alu.sv
// alu: combinational ALU driven by a 12-bit one-hot alu_op
module alu
  import exe_stage_pkg::*;
(
  input  logic [11:0] alu_op,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  output logic [31:0] alu_result
);
  logic [31:0] sra_res;
  assign sra_res = $unsigned($signed(src1) >>> src2[4:0]);
  assign alu_result = ({32{alu_op[ALU_ADD]}} & (src1 + src2))
                    | ({32{alu_op[ALU_SUB]}} & (src1 - src2))
                    | ({32{alu_op[ALU_SLT]}} & {31'b0, $signed(src1) < $signed(src2)})
                    | ({32{alu_op[ALU_SLTU]}} & {31'b0, src1 < src2})
                    | ({32{alu_op[ALU_AND]}} & (src1 & src2))
                    | ({32{alu_op[ALU_NOR]}} & ~(src1 | src2))
                    | ({32{alu_op[ALU_OR]}} & (src1 | src2))
                    | ({32{alu_op[ALU_XOR]}} & (src1 ^ src2))
                    | ({32{alu_op[ALU_SLL]}} & (src1 << src2[4:0]))
                    | ({32{alu_op[ALU_SRL]}} & (src1 >> src2[4:0]))
                    | ({32{alu_op[ALU_SRA]}} & sra_res)
                    | ({32{alu_op[ALU_LUI]}} & src2);
endmodule

// File: rtl/exe_stage_div.sv
// iter_divider: restoring shift-subtract divider, one step per cycle, truncating signed fix-up
module iter_divider
  import exe_stage_pkg::*;
#(
  parameter int W = DIV_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         signed_op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ack,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder
);
  localparam int CW = $clog2(W);
  div_state_t state;
  logic [CW-1:0] cnt;
  logic [W-1:0] quo, rem, dvs;
  logic neg_q, neg_r, dz, sa, sb, ge;
  logic [W:0] r_shift, diff;
  assign sa = signed_op & a[W-1];
  assign sb = signed_op & b[W-1];
  assign r_shift = {rem, quo[W-1]};
  assign diff = r_shift - {1'b0, dvs};
  assign ge = !diff[W];
  assign busy = state == DIV_RUN;
  assign done = state == DIV_DONE;
  // divide-by-zero leaves |a| in rem, so only the quotient needs overriding
  assign quotient = dz ? '1 : (neg_q ? -quo : quo);
  assign remainder = neg_r ? -rem : rem;
  always_ff @(posedge clk)
    if (reset) begin
      state <= DIV_IDLE;
      cnt <= '0;
      quo <= '0;
      rem <= '0;
      dvs <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      dz <= 1'b0;
    end else
      case (state)
        DIV_IDLE:
          if (start) begin
            state <= DIV_RUN;
            cnt <= '0;
            quo <= sa ? -a : a;
            rem <= '0;
            dvs <= sb ? -b : b;
            neg_q <= sa ^ sb;
            neg_r <= sa;
            dz <= b == '0;
          end
        DIV_RUN: begin
          quo <= {quo[W-2:0], ge};
          rem <= ge ? diff[W-1:0] : r_shift[W-1:0];
          cnt <= cnt + 1'b1;
          if (cnt == CW'(W - 1)) state <= DIV_DONE;
        end
        default: if (ack) state <= DIV_IDLE;
      endcase
endmodule

// File: rtl/exe_stage.sv
// exe_stage: EXE pipeline stage with ALU, iterative DIV/MOD stall, SRAM request and ID forwarding
// EXE_DIV_STALL_CNT_EN adds div_stall_cnt counting divider stall cycles
module exe_stage
  import exe_stage_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               ds2es_valid,
  output logic               es_allowin,
  input  logic [DS2ES_W-1:0] ds2es_bus,
  input  logic               ms_allowin,
  output logic               es2ms_valid,
  output logic [ES2MS_W-1:0] es2ms_bus,
  output logic               data_sram_en,
  output logic [3:0]         data_sram_we,
  output logic [31:0]        data_sram_addr,
  output logic [31:0]        data_sram_wdata,
  output logic               exe_rf_we,
  output logic [4:0]         exe_dest,
  output logic               exe_res_from_mem,
  output logic [31:0]        exe_fwd_data
`ifdef EXE_DIV_STALL_CNT_EN
  ,
  output logic [31:0]        div_stall_cnt
`endif
);
  logic es_valid, es_ready_go, div_busy, div_done, div_en, mem_we, res_from_mem, gr_we;
  logic [DS2ES_W-1:0] ds_r;
  logic [31:0] pc, src1, src2, st_data, alu_result, quotient, remainder, result;
  logic [11:0] alu_op;
  logic [2:0] div_op;
  logic [4:0] dest;
  assign pc = ds_r[DS_PC +: 32];
  assign alu_op = ds_r[DS_ALU_OP +: 12];
  assign src1 = ds_r[DS_SRC1 +: 32];
  assign src2 = ds_r[DS_SRC2 +: 32];
  assign st_data = ds_r[DS_ST_DATA +: 32];
  assign div_op = ds_r[DS_DIV_OP +: 3];
  assign mem_we = ds_r[DS_MEM_WE];
  assign res_from_mem = ds_r[DS_RES_FROM_MEM];
  assign dest = ds_r[DS_DEST +: 5];
  assign gr_we = ds_r[DS_GR_WE];
  assign div_en = div_op[DIV_EN_BIT];
  assign es_ready_go = !div_en | div_done;
  assign es_allowin = !es_valid | (es_ready_go & ms_allowin);
  assign es2ms_valid = es_valid & es_ready_go;
  always_ff @(posedge clk)
    if (reset) begin
      es_valid <= 1'b0;
      ds_r <= '0;
    end else begin
      if (es_allowin) es_valid <= ds2es_valid;
      if (ds2es_valid & es_allowin) ds_r <= ds2es_bus;
    end
  alu u_alu (
    .alu_op    (alu_op),
    .src1      (src1),
    .src2      (src2),
    .alu_result(alu_result)
  );
  iter_divider #(.W(DIV_W)) u_div (
    .clk      (clk),
    .reset    (reset),
    .start    (es_valid & div_en & !div_busy & !div_done),
    .signed_op(div_op[DIV_SIGNED_BIT]),
    .a        (src1),
    .b        (src2),
    .ack      (es2ms_valid & ms_allowin),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (quotient),
    .remainder(remainder)
  );
  assign result = div_en ? (div_op[DIV_REM_BIT] ? remainder : quotient) : alu_result;
  assign es2ms_bus = {pc, result, res_from_mem, dest, gr_we};
  assign data_sram_en = es_valid & (mem_we | res_from_mem) & ms_allowin;
  assign data_sram_we = {4{es_valid & mem_we & ms_allowin}};
  assign data_sram_addr = alu_result;
  assign data_sram_wdata = st_data;
  assign exe_rf_we = es_valid & gr_we;
  assign exe_dest = es_valid ? dest : 5'd0;
  assign exe_res_from_mem = es_valid & res_from_mem;
  assign exe_fwd_data = result;
`ifdef EXE_DIV_STALL_CNT_EN
  always_ff @(posedge clk)
    if (reset) div_stall_cnt <= '0;
    else if (es_valid & !es_ready_go) div_stall_cnt <= div_stall_cnt + 32'd1;
`endif
endmodule
